// File: rtl/dmux_stream_if.sv
// Stream bundle for dmux_stream: one tagged input stream, NUM_OUT output streams.
interface dmux_stream_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;

  // Producer of input words and consumer of the output ports.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dmux_stream.sv
// Stream demultiplexer: routes each tagged input word to one of NUM_OUT output
// streams through a single registered holding stage. Words tagged with an
// out-of-range select are accepted, discarded and counted.
//
// state | meaning
// EMPTY | holding stage has no word, in_ready=1
// FULL  | holding stage presents hold_data on port hold_sel
module dmux_stream #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dmux_stream_if.slave     bus,
  output logic             drop_err,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // One extra bit so NUM_OUT itself is representable for the range compare.
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hold_v;
  logic               sel_ready;
  logic               in_range;
  logic               accept;
  logic               drain;
  logic               in_ready_c;
  logic [NUM_OUT-1:0]       out_valid_c;
  logic [NUM_OUT*WIDTH-1:0] out_data_c;

  assign hold_v     = (state_q == FULL);
  assign in_range   = ({1'b0, bus.in_sel} < NUM_OUT_W);
  assign in_ready_c = !hold_v | sel_ready;
  assign accept     = bus.in_valid & in_ready_c;
  assign drain      = hold_v & sel_ready;

  // Pick the ready of the port currently held; other ports' ready is ignored.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (sel_q == SEL_W'(i)) sel_ready = bus.out_ready[i];
    end
  end

  // State register: holding stage, drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: drain empties the stage unless a routable word loads the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    if (drain) state_d = EMPTY;
    if (accept) begin
      if (in_range) begin
        state_d = FULL;
        sel_d   = bus.in_sel;
        data_d  = bus.in_data;
      end else begin
        drop_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs: decode held word onto its port; unselected ports read zero.
  always_comb begin
    out_valid_c = '0;
    out_data_c  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (hold_v && (sel_q == SEL_W'(i))) begin
        out_valid_c[i]                = 1'b1;
        out_data_c[i*WIDTH +: WIDTH]  = data_q;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign drop_err      = drop_q;
  assign drop_cnt      = cnt_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: an 8-port instance for routing/flow tests
// and a 6-port instance for out-of-range drop tests.
module tb_dmux_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmux_stream_if #(.WIDTH(16), .NUM_OUT(8), .SEL_W(4)) ifc8 ();
  dmux_stream_if #(.WIDTH(16), .NUM_OUT(6), .SEL_W(4)) ifc6 ();

  logic       drop_err8, drop_err6;
  logic [7:0] drop_cnt8, drop_cnt6;

  dmux_stream #(.WIDTH(16), .NUM_OUT(8), .SEL_W(4), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(ifc8.slave),
    .drop_err(drop_err8), .drop_cnt(drop_cnt8)
  );

  dmux_stream #(.WIDTH(16), .NUM_OUT(6), .SEL_W(4), .CNT_W(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(ifc6.slave),
    .drop_err(drop_err6), .drop_cnt(drop_cnt6)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int drop_pulses = 0;
  logic [19:0] sb_q[$];
  int xfer_cyc_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor for the 8-port instance: pops the scoreboard on every transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 128'($countones(ifc8.out_valid) > 1), 128'(0));
      for (int i = 0; i < 8; i++) begin
        if (ifc8.out_valid[i] && ifc8.out_ready[i]) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected", 128'(i + 1), 128'(0));
          end else begin
            logic [19:0] e;
            e = sb_q.pop_front();
            check("sb_sel", 128'(i), 128'(e[19:16]));
            check("sb_data", 128'(ifc8.out_data[i*16 +: 16]), 128'(e[15:0]));
          end
          xfer_cnt++;
          xfer_cyc_q.push_back(cyc);
        end
      end
      if (drop_err6) drop_pulses++;
    end
  end

  // Drive one word into the 8-port instance; record the expectation at handshake.
  task automatic send8(input logic [3:0] sel, input logic [15:0] data);
    int n = 0;
    ifc8.in_valid = 1'b1;
    ifc8.in_sel   = sel;
    ifc8.in_data  = data;
    @(negedge clk);
    while (!ifc8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc8.in_ready) check("send_timeout", 128'(0), 128'(1));
    else if (sel < 8) sb_q.push_back({sel, data});
    @(posedge clk); #1;
    ifc8.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_data;
    int base;
    ifc8.in_valid = 1'b1; ifc8.in_sel = 4'd1; ifc8.in_data = 16'h5555; ifc8.out_ready = '1;
    ifc6.in_valid = 1'b1; ifc6.in_sel = 4'd7; ifc6.in_data = 16'h0;    ifc6.out_ready = '1;
    rst_n = 1'b0;

    // 1: reset with in_valid asserted
    tick(2);
    check("rst_out_valid", 128'(ifc8.out_valid), 128'(0));
    check("rst_out_data", 128'(ifc8.out_data), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt8), 128'(0));
    check("rst_drop_err", 128'(drop_err8), 128'(0));
    check("rst6_drop_cnt", 128'(drop_cnt6), 128'(0));
    ifc8.in_valid = 1'b0;
    ifc6.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(ifc8.in_ready), 128'(1));
    check("rst_out_valid_after", 128'(ifc8.out_valid), 128'(0));
    @(posedge clk); #1;

    // 2: single route to port 5
    ifc8.out_ready = 8'hFF;
    send8(4'd5, 16'hBEEF);
    exp_data = '0;
    exp_data[5*16 +: 16] = 16'hBEEF;
    check("route_valid", 128'(ifc8.out_valid), 128'h20);
    check("route_data", 128'(ifc8.out_data), exp_data);
    tick(2);
    check("route_drained", 128'(ifc8.out_valid), 128'(0));

    // 3: back-pressure on port 2
    base = xfer_cnt;
    ifc8.out_ready = 8'hFB;
    send8(4'd2, 16'h1234);
    ifc8.in_valid = 1'b1; ifc8.in_sel = 4'd0; ifc8.in_data = 16'hAAAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(ifc8.in_ready), 128'(0));
      check("stall_valid", 128'(ifc8.out_valid), 128'h04);
      check("stall_data", 128'(ifc8.out_data[2*16 +: 16]), 128'h1234);
      @(posedge clk); #1;
    end
    ifc8.in_valid = 1'b0;
    ifc8.out_ready = 8'hFF;
    tick(3);
    check("stall_once", 128'(xfer_cnt - base), 128'(1));
    check("stall_sb_empty", 128'(sb_q.size()), 128'(0));

    // 4: streaming 8 words back to back
    xfer_cyc_q.delete();
    for (int s = 0; s < 8; s++) send8(4'(s), 16'hC000 + 16'(s * 17));
    tick(3);
    check("stream_count", 128'(xfer_cyc_q.size()), 128'(8));
    if (xfer_cyc_q.size() == 8)
      check("stream_span", 128'(xfer_cyc_q[7] - xfer_cyc_q[0]), 128'(7));
    check("stream_sb_empty", 128'(sb_q.size()), 128'(0));

    // 6: reset while stalled on port 3
    base = xfer_cnt;
    ifc8.out_ready = 8'hF7;
    send8(4'd3, 16'h3333);
    check("pre_rst_valid", 128'(ifc8.out_valid), 128'h08);
    rst_n = 1'b0;
    tick(1);
    check("midrst_valid", 128'(ifc8.out_valid), 128'(0));
    sb_q.delete();
    rst_n = 1'b1;
    ifc8.out_ready = 8'hFF;
    tick(3);
    check("midrst_never", 128'(xfer_cnt - base), 128'(0));
    check("midrst_in_ready", 128'(ifc8.in_ready), 128'(1));

    // 5: out-of-range drops on the 6-port instance
    drop_pulses = 0;
    ifc6.in_valid = 1'b1; ifc6.in_sel = 4'd7; ifc6.in_data = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("drop_err_hi", 128'(drop_err6), 128'(1));
      check("drop_no_valid", 128'(ifc6.out_valid), 128'(0));
    end
    ifc6.in_valid = 1'b0;
    tick(1);
    check("drop_err_lo", 128'(drop_err6), 128'(0));
    check("drop_cnt3", 128'(drop_cnt6), 128'(3));
    check("drop_pulses", 128'(drop_pulses), 128'(3));
    ifc6.in_valid = 1'b1;
    tick(257);
    ifc6.in_valid = 1'b0;
    tick(1);
    check("drop_sat", 128'(drop_cnt6), 128'(255));
    check("drop_sat_valid", 128'(ifc6.out_valid), 128'(0));
    // an in-range word still routes after saturation
    ifc6.in_valid = 1'b1; ifc6.in_sel = 4'd4; ifc6.in_data = 16'h4444;
    tick(1);
    ifc6.in_valid = 1'b0;
    check("p6_route_valid", 128'(ifc6.out_valid), 128'h10);
    check("p6_route_data", 128'(ifc6.out_data[4*16 +: 16]), 128'h4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
